// File: rtl/mult_8b_seq.sv
// Sequencer for the dual-rail reversible array multiplier: loads operands, computes the rows forward,
// captures the product, then uncomputes the rows in reverse and checks that the array is back at zero.
module mult_8b_seq #(
    parameter int N_STAGES = 8,
    parameter int SETTLE   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [7:0]          a_in,
    input  logic [7:0]          b_in,
    output logic [7:0]          a_p,
    output logic [7:0]          a_n,
    output logic [7:0]          b_p,
    output logic [7:0]          b_n,
    output logic [N_STAGES-1:0] fwd_en,
    output logic [N_STAGES-1:0] bwd_en,
    input  logic [15:0]         p_in,
    output logic [15:0]         result,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                busy,
    output logic                clean_err
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int STG_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(N_STAGES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_FWD     = 3'd2,
        S_CAPTURE = 3'd3,
        S_BWD     = 3'd4,
        S_UNLOAD  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STG_W-1:0]    stg_q, stg_d;
    logic [N_STAGES-1:0] fwd_q, fwd_d;
    logic [N_STAGES-1:0] bwd_q, bwd_d;
    logic [15:0]         result_q, result_d;
    logic                res_valid_q, res_valid_d;
    logic                clean_err_q, clean_err_d;
    logic [7:0]          a_q, a_d;
    logic [7:0]          b_q, b_d;
    logic                phase_done;
    logic                drive;
    logic [STG_W-1:0]    stg_up;
    logic [STG_W-1:0]    stg_dn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            stg_q       <= '0;
            fwd_q       <= '0;
            bwd_q       <= '0;
            result_q    <= '0;
            res_valid_q <= 1'b0;
            clean_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stg_q       <= stg_d;
            fwd_q       <= fwd_d;
            bwd_q       <= bwd_d;
            result_q    <= result_d;
            res_valid_q <= res_valid_d;
            clean_err_q <= clean_err_d;
        end
    end

    // Operand latches never reach the outputs while idle, so they need no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stg_d       = stg_q;
        fwd_d       = fwd_q;
        bwd_d       = bwd_q;
        result_d    = result_q;
        res_valid_d = res_valid_q;
        clean_err_d = clean_err_q;
        a_d         = a_q;
        b_d         = b_q;
        phase_done  = (cnt_q == CNT_LAST);
        stg_up      = stg_q + STG_W'(1);
        stg_dn      = stg_q - STG_W'(1);

        // The consumer may take the result in any state.
        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_valid && start_ready) begin
                    a_d         = a_in;
                    b_d         = b_in;
                    clean_err_d = 1'b0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (phase_done) begin
                    cnt_d    = '0;
                    stg_d    = '0;
                    fwd_d[0] = 1'b1;
                    state_d  = S_FWD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FWD: begin
                if (phase_done) begin
                    cnt_d = '0;
                    if (stg_q == STG_LAST) begin
                        state_d = S_CAPTURE;
                    end else begin
                        stg_d         = stg_up;
                        fwd_d[stg_up] = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                result_d        = p_in;
                res_valid_d     = 1'b1;
                cnt_d           = '0;
                stg_d           = STG_LAST;
                bwd_d           = '0;
                bwd_d[STG_LAST] = 1'b1;
                state_d         = S_BWD;
            end
            S_BWD: begin
                if (phase_done) begin
                    cnt_d        = '0;
                    fwd_d[stg_q] = 1'b0;
                    bwd_d        = '0;
                    if (stg_q == '0) begin
                        state_d = S_UNLOAD;
                    end else begin
                        stg_d         = stg_dn;
                        bwd_d[stg_dn] = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_UNLOAD: begin
                if (phase_done) begin
                    cnt_d = '0;
                    if (p_in != 16'h0000) begin
                        clean_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Rails sit at the all-zero null spacer whenever the sequencer is idle.
    assign drive       = (state_q != S_IDLE);
    assign a_p         = drive ? a_q : 8'h00;
    assign a_n         = drive ? ~a_q : 8'h00;
    assign b_p         = drive ? b_q : 8'h00;
    assign b_n         = drive ? ~b_q : 8'h00;
    assign fwd_en      = fwd_q;
    assign bwd_en      = bwd_q;
    assign result      = result_q;
    assign res_valid   = res_valid_q;
    assign clean_err   = clean_err_q;
    assign busy        = drive;
    assign start_ready = (state_q == S_IDLE) && !res_valid_q && !rst;

endmodule

// File: tb/tb_mult_8b_seq.sv
// Scoreboard bench for mult_8b_seq: behavioural array stand-in on p_in, edge-accurate checks of
// rails, row enables, result handshake, clean check, async reset and a SETTLE=1 instance.
module tb_mult_8b_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [7:0]  a_in, b_in;
    logic [7:0]  a_p, a_n, b_p, b_n;
    logic [7:0]  fwd_en, bwd_en;
    logic [15:0] p_in;
    logic [15:0] result;
    logic        res_valid;
    logic        res_ready;
    logic        busy;
    logic        clean_err;

    logic        s1_start_valid;
    logic        s1_start_ready;
    logic [7:0]  s1_a_in, s1_b_in;
    logic [7:0]  s1_a_p, s1_a_n, s1_b_p, s1_b_n;
    logic [7:0]  s1_fwd_en, s1_bwd_en;
    logic [15:0] s1_p_in;
    logic [15:0] s1_result;
    logic        s1_res_valid;
    logic        s1_res_ready;
    logic        s1_busy;
    logic        s1_clean_err;

    logic [7:0]  cur_a, cur_b, s1_a, s1_b;
    logic        dirty;
    logic [15:0] exp_q[$];
    int          e;
    int          n_chk;
    int          n_fail;

    always #5 clk = ~clk;

    mult_8b_seq #(.N_STAGES(8), .SETTLE(2)) u_dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .a_in(a_in), .b_in(b_in), .a_p(a_p), .a_n(a_n), .b_p(b_p), .b_n(b_n),
        .fwd_en(fwd_en), .bwd_en(bwd_en), .p_in(p_in), .result(result),
        .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .clean_err(clean_err)
    );

    mult_8b_seq #(.N_STAGES(8), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start_valid(s1_start_valid), .start_ready(s1_start_ready),
        .a_in(s1_a_in), .b_in(s1_b_in), .a_p(s1_a_p), .a_n(s1_a_n), .b_p(s1_b_p), .b_n(s1_b_n),
        .fwd_en(s1_fwd_en), .bwd_en(s1_bwd_en), .p_in(s1_p_in), .result(s1_result),
        .res_valid(s1_res_valid), .res_ready(s1_res_ready), .busy(s1_busy), .clean_err(s1_clean_err)
    );

    // Array stand-in: full product once every row is computed, zero once all rows are uncomputed.
    assign p_in = (dirty && busy && fwd_en == 8'h00 && bwd_en == 8'h00) ? 16'h0001 :
                  (fwd_en == 8'hFF) ? 16'(cur_a) * 16'(cur_b) : 16'h0000;
    assign s1_p_in = (s1_fwd_en == 8'hFF) ? 16'(s1_a) * 16'(s1_b) : 16'h0000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic do_accept(input logic [7:0] a, input logic [7:0] b);
        int n;
        @(negedge clk);
        start_valid = 1'b1;
        a_in = a;
        b_in = b;
        n = 0;
        while (!start_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) begin
            check_eq("accept_timeout", {31'd0, start_ready}, 32'd1);
            start_valid = 1'b0;
        end else begin
            cur_a = a;
            cur_b = b;
            exp_q.push_back(16'(a) * 16'(b));
            @(posedge clk);
            #1;
            start_valid = 1'b0;
            a_in = 8'h00;
            b_in = 8'h00;
            e = 0;
        end
    endtask

    // Walks one operation from the accept edge (E0) through E37.
    task automatic run_body(input bit take, input bit exp_cerr);
        logic [7:0]  exp_fwd, exp_bwd, inv_a, inv_b;
        logic [15:0] exp_res;
        check_eq("busy_e0", {31'd0, busy}, 32'd1);
        check_eq("start_ready_e0", {31'd0, start_ready}, 32'd0);
        inv_a = ~cur_a;
        inv_b = ~cur_b;
        while (e < 37) begin
            tick();
            if (e == 1) begin
                check_eq("a_p_e1", {24'd0, a_p}, {24'd0, cur_a});
                check_eq("a_n_e1", {24'd0, a_n}, {24'd0, inv_a});
                check_eq("b_p_e1", {24'd0, b_p}, {24'd0, cur_b});
                check_eq("b_n_e1", {24'd0, b_n}, {24'd0, inv_b});
                check_eq("clean_err_e1", {31'd0, clean_err}, 32'd0);
                check_eq("fwd_en_e1", {24'd0, fwd_en}, 32'd0);
            end
            if (e >= 2 && e <= 16 && (e % 2) == 0) begin
                exp_fwd = 8'((9'h001 << ((e - 2) / 2 + 1)) - 9'h001);
                check_eq($sformatf("fwd_en_e%0d", e), {24'd0, fwd_en}, {24'd0, exp_fwd});
            end
            if (e == 18) begin
                check_eq("res_valid_e18", {31'd0, res_valid}, 32'd0);
            end
            if (e == 19) begin
                check_eq("res_valid_e19", {31'd0, res_valid}, 32'd1);
                if (exp_q.size() == 0) begin
                    check_eq("scoreboard_empty", 32'd0, 32'd1);
                end else begin
                    exp_res = exp_q.pop_front();
                    check_eq("result_e19", {16'd0, result}, {16'd0, exp_res});
                end
                if (take) res_ready = 1'b1;
            end
            if (e == 20 && take) begin
                check_eq("res_valid_taken", {31'd0, res_valid}, 32'd0);
                res_ready = 1'b0;
            end
            if (e >= 19 && e <= 33 && (e % 2) == 1) begin
                exp_bwd = 8'h80 >> ((e - 19) / 2);
                exp_fwd = 8'hFF >> ((e - 19) / 2);
                check_eq($sformatf("bwd_en_e%0d", e), {24'd0, bwd_en}, {24'd0, exp_bwd});
                check_eq($sformatf("fwd_en_e%0d", e), {24'd0, fwd_en}, {24'd0, exp_fwd});
            end
            if (e == 35) begin
                check_eq("fwd_en_e35", {24'd0, fwd_en}, 32'd0);
                check_eq("bwd_en_e35", {24'd0, bwd_en}, 32'd0);
                check_eq("busy_e35", {31'd0, busy}, 32'd1);
            end
            if (e == 36) begin
                check_eq("busy_e36", {31'd0, busy}, 32'd1);
                check_eq("a_p_e36", {24'd0, a_p}, {24'd0, cur_a});
            end
            if (e == 37) begin
                check_eq("busy_e37", {31'd0, busy}, 32'd0);
                check_eq("a_p_e37", {24'd0, a_p}, 32'd0);
                check_eq("a_n_e37", {24'd0, a_n}, 32'd0);
                check_eq("b_n_e37", {24'd0, b_n}, 32'd0);
                check_eq("clean_err_e37", {31'd0, clean_err}, {31'd0, exp_cerr});
                check_eq("start_ready_e37", {31'd0, start_ready}, {31'd0, take});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [15:0] exp_res;
        n_chk = 0;
        n_fail = 0;
        e = 0;
        rst = 1'b1;
        start_valid = 1'b0;
        a_in = 8'h00;
        b_in = 8'h00;
        res_ready = 1'b0;
        dirty = 1'b0;
        cur_a = 8'h00;
        cur_b = 8'h00;
        s1_a = 8'h00;
        s1_b = 8'h00;
        s1_start_valid = 1'b0;
        s1_a_in = 8'h00;
        s1_b_in = 8'h00;
        s1_res_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check_eq("rst_result", {16'd0, result}, 32'd0);
        check_eq("rst_fwd_en", {24'd0, fwd_en}, 32'd0);
        check_eq("rst_a_n", {24'd0, a_n}, 32'd0);
        check_eq("rst_start_ready", {31'd0, start_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_eq("start_ready_after_rst", {31'd0, start_ready}, 32'd1);

        // Basic and corner operands
        do_accept(8'h0D, 8'h0B);
        run_body(1'b1, 1'b0);
        do_accept(8'hFF, 8'hFF);
        run_body(1'b1, 1'b0);
        do_accept(8'h00, 8'hA5);
        run_body(1'b1, 1'b0);

        // Result backpressure: start_valid held high while the previous result is untaken
        do_accept(8'h21, 8'h07);
        run_body(1'b0, 1'b0);
        start_valid = 1'b1;
        a_in = 8'h5A;
        b_in = 8'h3C;
        while (e < 60) begin
            tick();
            check_eq($sformatf("bp_start_ready_e%0d", e), {31'd0, start_ready}, 32'd0);
            check_eq($sformatf("bp_busy_e%0d", e), {31'd0, busy}, 32'd0);
        end
        check_eq("bp_res_valid_e60", {31'd0, res_valid}, 32'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_eq("bp_res_valid_e61", {31'd0, res_valid}, 32'd0);
        check_eq("bp_start_ready_e61", {31'd0, start_ready}, 32'd1);
        do_accept(8'h5A, 8'h3C);
        run_body(1'b1, 1'b0);

        // Dirty array: clean_err sticks until the next accepted start
        dirty = 1'b1;
        do_accept(8'h12, 8'h34);
        run_body(1'b1, 1'b1);
        dirty = 1'b0;
        repeat (3) tick();
        check_eq("clean_err_sticky", {31'd0, clean_err}, 32'd1);
        do_accept(8'h9C, 8'h37);
        run_body(1'b1, 1'b0);

        // Asynchronous reset in the middle of the forward pass
        do_accept(8'h77, 8'h99);
        while (e < 9) tick();
        check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_a_p", {24'd0, a_p}, 32'd0);
        check_eq("mid_rst_a_n", {24'd0, a_n}, 32'd0);
        check_eq("mid_rst_b_p", {24'd0, b_p}, 32'd0);
        check_eq("mid_rst_b_n", {24'd0, b_n}, 32'd0);
        check_eq("mid_rst_fwd_en", {24'd0, fwd_en}, 32'd0);
        check_eq("mid_rst_bwd_en", {24'd0, bwd_en}, 32'd0);
        check_eq("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_eq("post_rst_start_ready", {31'd0, start_ready}, 32'd1);
        do_accept(8'h03, 8'h05);
        run_body(1'b1, 1'b0);

        // SETTLE=1 instance: result after 10 edges, idle again after 19
        @(negedge clk);
        s1_start_valid = 1'b1;
        s1_a_in = 8'hC3;
        s1_b_in = 8'h5E;
        check_eq("s1_start_ready", {31'd0, s1_start_ready}, 32'd1);
        s1_a = 8'hC3;
        s1_b = 8'h5E;
        exp_q.push_back(16'(s1_a) * 16'(s1_b));
        @(posedge clk);
        #1;
        s1_start_valid = 1'b0;
        for (k = 1; k <= 19; k++) begin
            @(posedge clk);
            #1;
            if (k == 9) check_eq("s1_res_valid_e9", {31'd0, s1_res_valid}, 32'd0);
            if (k == 10) begin
                check_eq("s1_res_valid_e10", {31'd0, s1_res_valid}, 32'd1);
                if (exp_q.size() == 0) begin
                    check_eq("s1_scoreboard_empty", 32'd0, 32'd1);
                end else begin
                    exp_res = exp_q.pop_front();
                    check_eq("s1_result", {16'd0, s1_result}, {16'd0, exp_res});
                end
            end
            if (k == 18) check_eq("s1_busy_e18", {31'd0, s1_busy}, 32'd1);
            if (k == 19) begin
                check_eq("s1_busy_e19", {31'd0, s1_busy}, 32'd0);
                check_eq("s1_clean_err", {31'd0, s1_clean_err}, 32'd0);
            end
        end

        check_eq("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
